// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshake and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 512
);
  logic [REQUESTERS-1:0]           req_load;
  logic [REQUESTERS-1:0]           req_write;
  logic [REQUESTERS*ADDR_BITS-1:0] req_addr;
  logic [REQUESTERS*DATA_BITS-1:0] req_wdata;
  logic [REQUESTERS-1:0]           grant;
  logic [ADDR_BITS-1:0]            mem_addr;
  logic [DATA_BITS-1:0]            mem_wdata;
  logic                            mem_read;
  logic                            mem_write;
  logic [DATA_BITS-1:0]            mem_rdata;
  logic [REQUESTERS-1:0]           rsp_valid;
  logic [DATA_BITS-1:0]            rsp_data;
  modport master (
    output req_load, req_write, req_addr, req_wdata, mem_rdata,
    input  grant, mem_addr, mem_wdata, mem_read, mem_write, rsp_valid, rsp_data
  );
  modport slave (
    input  req_load, req_write, req_addr, req_wdata, mem_rdata,
    output grant, mem_addr, mem_wdata, mem_read, mem_write, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port with tagged load responses; ARB_PROTO_CHECK_EN adds sticky proto_err
module mem_port_arbiter #(
  parameter int REQUESTERS   = 4,
  parameter int ADDR_BITS    = 16,
  parameter int DATA_BITS    = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic clock,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PROTO_CHECK_EN
  , output logic proto_err
`endif
);
  localparam int IDW = $clog2(REQUESTERS);
  logic [REQUESTERS-1:0] active, grant_c;
  logic [IDW-1:0]        ptr, gid, mem_id;
  logic                  any;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [DATA_BITS-1:0]  sel_wdata;
  logic                  sel_load, sel_write;
  logic [READ_LATENCY-1:0] tag_v;
  logic [IDW-1:0]          tag_id [READ_LATENCY];
  assign active    = bus.req_load | bus.req_write;
  assign grant_c   = any ? (REQUESTERS'(1) << gid) : '0;
  assign bus.grant = reset_n ? grant_c : '0;
  assign sel_addr  = bus.req_addr[int'(gid)*ADDR_BITS +: ADDR_BITS];
  assign sel_wdata = bus.req_wdata[int'(gid)*DATA_BITS +: DATA_BITS];
  assign sel_load  = bus.req_load[gid];
  assign sel_write = bus.req_write[gid];
  // first active requester at or above the pointer, wrapping; lowest offset wins
  always_comb begin
    any = 1'b0;
    gid = '0;
    for (int k = REQUESTERS-1; k >= 0; k--)
      if (active[(int'(ptr) + k) % REQUESTERS]) begin
        any = 1'b1;
        gid = IDW'((int'(ptr) + k) % REQUESTERS);
      end
  end
  // issue the granted request to memory; write wins over a simultaneous load
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ptr           <= '0;
      mem_id        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      bus.mem_read  <= any & sel_load & ~sel_write;
      bus.mem_write <= any & sel_write;
      if (any) begin
        ptr           <= (gid == IDW'(REQUESTERS-1)) ? '0 : gid + 1'b1;
        mem_id        <= gid;
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
      end
    end
  // tag each read with its requester and return data after the memory latency
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tag_v         <= '0;
      for (int j = 0; j < READ_LATENCY; j++) tag_id[j] <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      for (int j = READ_LATENCY-1; j > 0; j--) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
      tag_v[0]      <= bus.mem_read;
      tag_id[0]     <= mem_id;
      bus.rsp_valid <= tag_v[READ_LATENCY-1] ? (REQUESTERS'(1) << tag_id[READ_LATENCY-1]) : '0;
      if (tag_v[READ_LATENCY-1]) bus.rsp_data <= bus.mem_rdata;
    end
`ifdef ARB_PROTO_CHECK_EN
  logic [REQUESTERS-1:0] waiting;
  // sticky flag for load+write together or a waiting request withdrawn
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      waiting   <= '0;
      proto_err <= 1'b0;
    end else begin
      waiting <= active & ~bus.grant;
      if (|(bus.req_load & bus.req_write) || |(waiting & ~active)) proto_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency memory model
module tb_mem_port_arbiter;
  localparam int R = 4, AW = 16, DW = 512, RL = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0, n_cmp = 0, n_err = 0;
  typedef struct { int due; logic [R-1:0] v; logic [DW-1:0] d; } rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rp [RL+1];
  mem_port_arbiter_if #(.REQUESTERS(R), .ADDR_BITS(AW), .DATA_BITS(DW)) bus();
`ifdef ARB_PROTO_CHECK_EN
  logic proto_err;
`endif
  mem_port_arbiter #(.REQUESTERS(R), .ADDR_BITS(AW), .DATA_BITS(DW), .READ_LATENCY(RL)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
`ifdef ARB_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {64{8'hA5}} ^ DW'(a);
  endfunction
  // memory model: mem_rdata valid RL cycles after the read strobe cycle
  always @(negedge clock) begin
    for (int j = RL; j > 0; j--) rp[j] = rp[j-1];
    rp[0] = bus.mem_read ? (mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)] : pat(bus.mem_addr)) : '0;
    if (bus.mem_write) mem[int'(bus.mem_addr)] = bus.mem_wdata;
    bus.mem_rdata = rp[RL];
  end
  // response scoreboard
  always @(negedge clock) if (reset_n) begin
    if (bus.rsp_valid !== '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got valid=%b at cycle %0d, expected none", bus.rsp_valid, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_valid !== e.v || bus.rsp_data !== e.d || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp: got valid=%b cycle=%0d data=%h, expected valid=%b cycle=%0d data=%h",
                   bus.rsp_valid, cyc, bus.rsp_data[63:0], e.v, e.due, e.d[63:0]);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      n_cmp++;
      n_err++;
      e = exp_q.pop_front();
      $display("FAIL rsp_missing: got no response at cycle %0d, expected valid=%b due %0d", cyc, e.v, e.due);
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic set_req(input int i, input logic ld, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_load[i] = ld;
    bus.req_write[i] = wr;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_load = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) step();
    bus.req_load = 4'b1111;
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
    n_cmp++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b expected 00", {bus.mem_read, bus.mem_write}); end
    n_cmp++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_bus: got addr=%h expected 0", bus.mem_addr); end
    n_cmp++;
    if (bus.rsp_valid !== '0 || bus.rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp: got valid=%b expected 0", bus.rsp_valid); end
    bus.req_load = '0;
    step();
    reset_n = 1'b1;
  endtask
  task automatic test_round_robin();
    logic [R-1:0] g;
    for (int i = 0; i < R; i++) set_req(i, 1'b1, 1'b0, AW'(16'h40 + i), '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      g = R'(1) << (k % R);
      n_cmp++;
      if (bus.grant !== g) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", k, bus.grant, g); end
      if (k > 0) begin
        n_cmp++;
        if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rr_read%0d: got %b expected 1", k, bus.mem_read); end
      end
      exp_q.push_back('{cyc + RL + 2, g, pat(AW'(16'h40 + k % R))});
      step();
    end
    bus.req_load = '0;
    repeat (RL + 3) step();
  endtask
  task automatic test_single_load();
    set_req(2, 1'b1, 1'b0, 16'h0010, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b expected 0100", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b0100, pat(16'h0010)});
    step();
    set_req(2, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0010) begin
      n_err++; $display("FAIL single_issue: got rd=%b wr=%b addr=%h expected 1 0 0010", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    step();
    @(negedge clock);
    n_cmp++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0010) begin
      n_err++; $display("FAIL single_idle: got rd=%b addr=%h expected 0 0010", bus.mem_read, bus.mem_addr);
    end
    repeat (RL + 2) step();
  endtask
  task automatic test_wrap();
    set_req(0, 1'b1, 1'b0, 16'h0020, '0);
    set_req(3, 1'b1, 1'b0, 16'h0023, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL wrap_first: got %b expected 1000", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b1000, pat(16'h0023)});
    step();
    set_req(3, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL wrap_second: got %b expected 0001", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b0001, pat(16'h0020)});
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b1, 1'b0, 16'h0022, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL wrap_lone_a: got %b expected 0100", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b0100, pat(16'h0022)});
    step();
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL wrap_lone_b: got %b expected 0100", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b0100, pat(16'h0022)});
    step();
    set_req(2, 1'b0, 1'b0, '0, '0);
    repeat (RL + 2) step();
  endtask
  task automatic test_write_read();
    set_req(1, 1'b0, 1'b1, 16'h0005, DW'(32'h1234));
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL wr_grant: got %b expected 0010", bus.grant); end
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(3, 1'b1, 1'b0, 16'h0005, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0005 || bus.mem_wdata !== DW'(32'h1234)) begin
      n_err++; $display("FAIL wr_issue: got wr=%b rd=%b addr=%h data=%h expected 1 0 0005 1234", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata[31:0]);
    end
    n_cmp++;
    if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL rd_grant: got %b expected 1000", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b1000, DW'(32'h1234)});
    step();
    set_req(3, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 16'h0005) begin
      n_err++; $display("FAIL rd_issue: got rd=%b wr=%b addr=%h expected 1 0 0005", bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    repeat (RL + 2) step();
  endtask
  task automatic test_reset_midflight();
    set_req(1, 1'b1, 1'b0, 16'h0077, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL mid_grant: got %b expected 0010", bus.grant); end
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_read, bus.mem_write, bus.grant, bus.rsp_valid} !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.rsp_data !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got rd=%b wr=%b grant=%b rsp=%b addr=%h expected all 0",
                        bus.mem_read, bus.mem_write, bus.grant, bus.rsp_valid, bus.mem_addr);
    end
    step();
    reset_n = 1'b1;
    repeat (RL + 3) step();
    set_req(0, 1'b1, 1'b0, 16'h0050, '0);
    set_req(3, 1'b1, 1'b0, 16'h0053, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_reset: got %b expected 0001", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b0001, pat(16'h0050)});
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL mid_after: got %b expected 1000", bus.grant); end
    exp_q.push_back('{cyc + RL + 2, 4'b1000, pat(16'h0053)});
    step();
    set_req(3, 1'b0, 1'b0, '0, '0);
    repeat (RL + 2) step();
  endtask
  task automatic test_load_write_conflict();
    reset_n = 1'b0;
    step();
`ifdef ARB_PROTO_CHECK_EN
    n_cmp++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_reset: got %b expected 0", proto_err); end
`endif
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 16'h0030, DW'(32'hBEEF));
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL conflict_grant: got %b expected 0001", bus.grant); end
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_wdata !== DW'(32'hBEEF)) begin
      n_err++; $display("FAIL conflict_issue: got wr=%b rd=%b data=%h expected 1 0 beef", bus.mem_write, bus.mem_read, bus.mem_wdata[31:0]);
    end
`ifdef ARB_PROTO_CHECK_EN
    n_cmp++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_set: got %b expected 1", proto_err); end
`endif
    repeat (3) step();
`ifdef ARB_PROTO_CHECK_EN
    @(negedge clock);
    n_cmp++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
`endif
    set_req(2, 1'b1, 1'b0, 16'h0030, '0);
    @(negedge clock);
    exp_q.push_back('{cyc + RL + 2, 4'b0100, DW'(32'hBEEF)});
    step();
    set_req(2, 1'b0, 1'b0, '0, '0);
    repeat (RL + 2) step();
`ifdef ARB_PROTO_CHECK_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0060, '0);
    set_req(1, 1'b1, 1'b0, 16'h0061, '0);
    @(negedge clock);
    exp_q.push_back('{cyc + RL + 2, 4'b0001, pat(16'h0060)});
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    n_cmp++;
    if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_clean: got %b expected 0", proto_err); end
    step();
    @(negedge clock);
    n_cmp++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_withdraw: got %b expected 1", proto_err); end
    repeat (RL + 2) step();
`endif
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_single_load();
    test_wrap();
    test_write_read();
    test_reset_midflight();
    test_load_write_conflict();
    repeat (4) step();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rsp_drain: got %0d pending expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
